// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clear sequencer and dual prioritised writes
//
// Purpose:
//   DEPTH = 2**AW entries of DW bits, NUM_RD combinational read ports and two
//   write ports (port 1 wins on a same-address collision). After reset a
//   sequencer zeroes every entry, one per cycle, and then raises ready.
//   With ZERO_REG=1, entry 0 always reads 0 and ignores writes.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   rd_addr/rd_data  packed read ports; port k uses [k*AW +: AW] / [k*DW +: DW]
//   wr_en0/addr0/data0  write port 0
//   wr_en1/addr1/data1  write port 1 (higher priority)
//   ready            1 once the clear sequence has finished
//   wr_conflict      registered one-cycle pulse after a same-address dual write
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined: in RUN, a read that matches an enabled write in the same cycle
//   returns the write data (port 1 first). Undefined: reads see the array only.

module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  input  logic                 wr_en0,
  input  logic [AW-1:0]        wr_addr0,
  input  logic [DW-1:0]        wr_data0,
  input  logic                 wr_en1,
  input  logic [AW-1:0]        wr_addr1,
  input  logic [DW-1:0]        wr_data1,
  output logic                 ready,
  output logic                 wr_conflict
);

  localparam int DEPTH = 1 << AW;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]    r_state;
  logic [AW-1:0] r_clr_cnt;
  logic          r_ready;
  logic          r_wr_conflict;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_run;
  logic w_zero0;
  logic w_zero1;
  logic w_same_addr;
  logic w_we0;
  logic w_we1;
  logic w_conflict;

  assign w_run       = (r_state == S_RUN);
  assign w_zero0     = (ZERO_REG != 0) && (wr_addr0 == '0);
  assign w_zero1     = (ZERO_REG != 0) && (wr_addr1 == '0);
  assign w_same_addr = wr_en0 && wr_en1 && (wr_addr0 == wr_addr1);

  // Port 0 is suppressed on a collision so port 1's data lands unambiguously.
  assign w_we0      = w_run && wr_en0 && !w_zero0 && !w_same_addr;
  assign w_we1      = w_run && wr_en1 && !w_zero1;
  assign w_conflict = w_run && w_same_addr && !w_zero1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_CLEAR;
      r_clr_cnt     <= '0;
      r_ready       <= 1'b0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_wr_conflict <= w_conflict;
      if (r_state == S_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (r_clr_cnt == AW'(DEPTH - 1)) begin
          r_state <= S_RUN;
          r_ready <= 1'b1;
        end
      end
    end
  end

  // The array has no reset; it is left alone in the reset cycle and zeroed by
  // the sequencer afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else begin
        if (w_we0) r_mem[wr_addr0] <= wr_data0;
        if (w_we1) r_mem[wr_addr1] <= wr_data1;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_val;

      assign w_addr = rd_addr[k*AW +: AW];

      // Reads are forced to 0 until ready so unwritten entries never leak X.
      always_comb begin
        w_val = '0;
        if (!w_run) begin
          w_val = '0;
        end else if ((ZERO_REG != 0) && (w_addr == '0)) begin
          w_val = '0;
        end else begin
`ifdef REGFILE_BYPASS_EN
          if (wr_en1 && (wr_addr1 == w_addr)) begin
            w_val = wr_data1;
          end else if (wr_en0 && (wr_addr0 == w_addr)) begin
            w_val = wr_data0;
          end else begin
            w_val = r_mem[w_addr];
          end
`else
          w_val = r_mem[w_addr];
`endif
        end
      end

      assign rd_data[k*DW +: DW] = w_val;
    end
  endgenerate

  assign ready       = r_ready;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (default parameters)

module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wr_en0;
  logic [4:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic        wr_en1;
  logic [4:0]  wr_addr1;
  logic [31:0] wr_data1;
  logic        ready;
  logic        wr_conflict;

  int n_checks;
  int n_errors;
  int cycles;

  regfile_mp #(.DW(32), .AW(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_en0      (wr_en0),
    .wr_addr0    (wr_addr0),
    .wr_data0    (wr_data0),
    .wr_en1      (wr_en1),
    .wr_addr1    (wr_addr1),
    .wr_data1    (wr_data1),
    .ready       (ready),
    .wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle_wr();
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
  endtask

  // Counts posedges from release until ready, bounded.
  task automatic wait_ready(input string tag);
    cycles = 0;
    while (!ready && cycles < 100) begin
      tick();
      cycles++;
    end
    check(tag, 32'(cycles), 32'd32);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    rd_addr = '0;
    idle_wr();

    tick();
    tick();
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_conflict", {31'd0, wr_conflict}, 32'd0);
    rst = 1'b0;

    // Clear sequence; dual same-address writes during CLEAR must be ignored.
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h5555_5555;
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h6666_6666;
    cycles = 0;
    while (!ready && cycles < 100) begin
      tick();
      cycles++;
      if (cycles == 5) begin
        check("clear_conflict", {31'd0, wr_conflict}, 32'd0);
        set_rd(5'd1, 5'd9);
        check("clear_rd0", rd_data[31:0], 32'd0);
        check("clear_rd1", rd_data[63:32], 32'd0);
      end
      if (cycles == 31) check("ready_at_31", {31'd0, ready}, 32'd0);
    end
    idle_wr();
    check("clear_len", 32'(cycles), 32'd32);

    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      check($sformatf("clr_p0_a%0d", i), rd_data[31:0], 32'd0);
      check($sformatf("clr_p1_a%0d", 31 - i), rd_data[63:32], 32'd0);
    end

    // Basic write / read.
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEAD_BEEF;
    tick();
    idle_wr();
    set_rd(5'd5, 5'd5);
    check("basic_p0", rd_data[31:0], 32'hDEAD_BEEF);
    check("basic_p1", rd_data[63:32], 32'hDEAD_BEEF);

    // Same-address dual write: port 1 wins, one-cycle conflict pulse.
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h1111_1111;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h2222_2222;
    tick();
    idle_wr();
    set_rd(5'd7, 5'd5);
    check("dual_same_data", rd_data[31:0], 32'h2222_2222);
    check("dual_same_conf", {31'd0, wr_conflict}, 32'd1);
    tick();
    check("dual_same_conf_end", {31'd0, wr_conflict}, 32'd0);

    // Different-address dual write.
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h1111_1111;
    wr_en1 = 1'b1; wr_addr1 = 5'd8; wr_data1 = 32'h2222_2222;
    tick();
    idle_wr();
    set_rd(5'd7, 5'd8);
    check("dual_diff_a7", rd_data[31:0], 32'h1111_1111);
    check("dual_diff_a8", rd_data[63:32], 32'h2222_2222);
    check("dual_diff_conf", {31'd0, wr_conflict}, 32'd0);

    // Zero register.
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFF_FFFF;
    wr_en1 = 1'b1; wr_addr1 = 5'd0; wr_data1 = 32'hFFFF_FFFF;
    tick();
    idle_wr();
    set_rd(5'd0, 5'd0);
    check("zero_rd", rd_data[31:0], 32'd0);
    check("zero_conf", {31'd0, wr_conflict}, 32'd0);

    // Read during write.
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h0000_0001;
    tick();
    wr_data0 = 32'hA5A5_A5A5;
    set_rd(5'd3, 5'd8);
`ifdef REGFILE_BYPASS_EN
    check("rdw_same_cycle", rd_data[31:0], 32'hA5A5_A5A5);
`else
    check("rdw_same_cycle", rd_data[31:0], 32'h0000_0001);
`endif
    check("rdw_other_port", rd_data[63:32], 32'h2222_2222);
    tick();
    idle_wr();
    set_rd(5'd3, 5'd3);
    check("rdw_next_cycle", rd_data[31:0], 32'hA5A5_A5A5);

    // Port 1 alone to a non-zero address.
    wr_en1 = 1'b1; wr_addr1 = 5'd12; wr_data1 = 32'h1234_5678;
    tick();
    idle_wr();
    set_rd(5'd12, 5'd31);
    check("p1_write", rd_data[31:0], 32'h1234_5678);

    // Reset in RUN, then again mid-clear at clr_cnt = 10.
    rst = 1'b1;
    tick();
    check("run_reset_ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready("midclear_len");
    set_rd(5'd12, 5'd3);
    check("midclear_a12", rd_data[31:0], 32'd0);
    check("midclear_a3", rd_data[63:32], 32'd0);
    set_rd(5'd7, 5'd8);
    check("midclear_a7", rd_data[31:0], 32'd0);
    check("midclear_a8", rd_data[63:32], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file, the next generation of the CPU's 32x32 register bank. It provides NUM_RD combinational read ports and two write ports with fixed priority. Register 0 is optionally hardwired to zero. A synchronous clear sequencer zeroes every entry after reset, and a ready flag tells the pipeline when the file may be used. It sits between decode (reads) and writeback (writes).

Parameters:
DW, 32, data width in bits
AW, 5, address width; DEPTH = 2**AW entries
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset
rd_addr  in  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NUM_RD*DW  read data; port k uses bits [k*DW +: DW]
wr_en0  in  1  write enable, port 0
wr_addr0  in  AW  write address, port 0
wr_data0  in  DW  write data, port 0
wr_en1  in  1  write enable, port 1 (higher priority)
wr_addr1  in  AW  write address, port 1
wr_data1  in  DW  write data, port 1
ready  out  1  1 = clear sequence finished; file usable
wr_conflict  out  1  registered one-cycle pulse on a same-address dual write

Interface rule (already decided): one clock; reset is synchronous and active-high. Ports are clk and rst.

Behaviour:
- Reset: when rst=1 at a posedge:
  - state <= CLEAR, clr_cnt <= 0, ready <= 0, wr_conflict <= 0.
  - Array contents are not touched in the reset cycle itself.
- FSM CLEAR:
  - Each cycle, entry[clr_cnt] <= 0 and clr_cnt increments.
  - When clr_cnt == DEPTH-1, that entry is cleared, the state moves to RUN and ready <= 1.
  - The sequence takes exactly DEPTH cycles after rst deasserts. The counter is AW bits wide and must not wrap before the transition.
- In CLEAR, wr_en0 and wr_en1 are ignored, all rd_data read 0, and wr_conflict stays 0.
- Reset asserted mid-CLEAR or in RUN restarts the sequence from clr_cnt=0.
- FSM RUN: stays in RUN until rst.
- Reads: combinational, zero latency.
  - rd_data[k] = entry[rd_addr[k]].
  - If ZERO_REG=1 and rd_addr[k]==0, the port returns 0.
- Writes: take effect at the posedge.
  - wr_en0 writes wr_data0 to wr_addr0; wr_en1 writes wr_data1 to wr_addr1.
  - Both enabled, different addresses: both entries are written.
  - Both enabled, same address: port 1's data wins. wr_conflict <= 1 for the following cycle only, unless ZERO_REG=1 and the address is 0.
  - Otherwise wr_conflict <= 0.
  - ZERO_REG=1: writes to address 0 are dropped and entry 0 stays 0.
- Read during write (same address, same cycle), without the bypass feature: the read returns the old value, and the new value is visible from the next cycle.
- No X on any output after reset. rd_data is fully defined for every address once ready=1.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - In RUN, a read port whose address matches an enabled write port in the same cycle returns that write data combinationally.
  - Port 1 takes priority over port 0.
  - The ZERO_REG rule still forces address 0 to read 0.
  - rd_data then depends combinationally on wr_en, wr_addr and wr_data.
- Undefined:
  - No forwarding path; reads return the array contents only, i.e. the old value.
  - There is no combinational path from the write ports to rd_data.

Test Plan:
- Clear sequence: hold rst for 2 cycles, then release, with default params.
  - ready=0 for exactly 32 cycles and goes 1 on the 32nd posedge.
  - Every rd_addr 0..31 reads 0x00000000.
- Basic write/read: in RUN, write 0xDEADBEEF to addr 5 via port 0, then read addr 5 on both ports the next cycle.
  - Both ports read 0xDEADBEEF.
- Dual write: port0 writes addr 7 = 0x11111111 and port1 writes addr 7 = 0x22222222 in the same cycle.
  - addr 7 reads 0x22222222.
  - wr_conflict=1 for exactly one cycle.
  - The same test with addrs 7 and 8 writes both entries and leaves wr_conflict=0.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to addr 0 on both ports.
  - addr 0 reads 0.
  - wr_conflict stays 0.
- Reset mid-clear: assert rst when clr_cnt=10, then release.
  - ready rises exactly 32 cycles after release.
  - Any value written before the reset reads 0.
- Read-during-write: write 0xA5A5A5A5 to addr 3 (previously 0x1) while reading addr 3 in the same cycle.
  - Without REGFILE_BYPASS_EN, rd_data=0x00000001 in that cycle.
  - With REGFILE_BYPASS_EN, rd_data=0xA5A5A5A5 in that cycle.
  - In both builds, rd_data=0xA5A5A5A5 the next cycle.
